// File: rtl/cpu_controller.sv
// cpu_controller: IR + decoder + multi-cycle FSM, one strobe-set per clock, registered Moore outputs.
// Optional `ILLEGAL_TRAP_EN: illegal encodings halt with err=1 until reset (otherwise they retire as no-ops).
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        err,
  output logic [2:0]  nsel,
  output logic [1:0]  vsel,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_EXEC, S_WR_REG
`ifdef ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic        r_w, r_write, r_loada, r_loadb, r_loadc, r_loads, r_asel;
  logic [2:0]  r_nsel;
  logic [1:0]  r_vsel;

  logic w_is_alu, w_is_movi, w_is_movr, w_is_cmp, w_is_mvn;
  assign w_is_alu  = (r_ir[15:13] == 3'b101);
  assign w_is_movi = (r_ir[15:13] == 3'b110) && (r_ir[12:11] == 2'b10);
  assign w_is_movr = (r_ir[15:13] == 3'b110) && (r_ir[12:11] == 2'b00);
  assign w_is_cmp  = w_is_alu && (r_ir[12:11] == 2'b01);
  assign w_is_mvn  = w_is_alu && (r_ir[12:11] == 2'b11);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:   if (s) w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_movi)                 w_next = S_WR_IMM;
        else if (w_is_movr || w_is_mvn) w_next = S_GET_B;
        else if (w_is_alu)             w_next = S_GET_A;
`ifdef ILLEGAL_TRAP_EN
        else                           w_next = S_HALT;
`else
        else                           w_next = S_WAIT;
`endif
      end
      S_GET_A:  w_next = S_GET_B;
      S_GET_B:  w_next = S_EXEC;
      S_EXEC:   w_next = w_is_cmp ? S_WAIT : S_WR_REG;
      S_WR_IMM: w_next = S_WAIT;
      S_WR_REG: w_next = S_WAIT;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:   w_next = S_HALT;
`endif
      default:  w_next = S_WAIT;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= 16'h0000;
      r_w     <= 1'b1;
      r_nsel  <= 3'b000;
      r_vsel  <= 2'b00;
      r_write <= 1'b0;
      r_loada <= 1'b0;
      r_loadb <= 1'b0;
      r_loadc <= 1'b0;
      r_loads <= 1'b0;
      r_asel  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && load) r_ir <= in;
      r_w     <= (w_next == S_WAIT);
      r_nsel  <= (w_next == S_WR_IMM || w_next == S_GET_A) ? 3'b100 :
                 (w_next == S_GET_B)  ? 3'b001 :
                 (w_next == S_WR_REG) ? 3'b010 : 3'b000;
      r_vsel  <= (w_next == S_WR_IMM) ? 2'b01 : 2'b00;
      r_write <= (w_next == S_WR_IMM) || (w_next == S_WR_REG);
      r_loada <= (w_next == S_GET_A);
      r_loadb <= (w_next == S_GET_B);
      r_loadc <= (w_next == S_EXEC) && !w_is_cmp;
      r_loads <= (w_next == S_EXEC) && w_is_cmp;
      r_asel  <= (w_next == S_EXEC) && (w_is_movr || w_is_mvn);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= (w_next == S_HALT);
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign w      = r_w;
  assign nsel   = r_nsel;
  assign vsel   = r_vsel;
  assign write  = r_write;
  assign loada  = r_loada;
  assign loadb  = r_loadb;
  assign loadc  = r_loadc;
  assign loads  = r_loads;
  assign asel   = r_asel;
  assign bsel   = 1'b0;
  assign ALUop  = w_is_alu ? r_ir[12:11] : 2'b00;
  assign shift  = (w_is_alu || w_is_movr) ? r_ir[4:3] : 2'b00;
  assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};

endmodule
